// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: shift FSM encodings, frame geometry and the scan codes
// the downstream decode stage keys on.
package ps2_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RECV = 1'b1;

    localparam int FRAME_BITS = 11;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam logic [7:0] SHIFT_CODE = 8'h12;
    localparam logic [7:0] CTRL_CODE  = 8'h14;

    // Frame layout: [0] start, [8:1] data LSB first, [9] odd parity, [10] stop.
    function automatic logic frame_ok(input logic [FRAME_BITS-1:0] f);
        return !f[0] && f[10] && (^f[9:1]);
    endfunction

endpackage

// File: rtl/ps2_fifo.sv
// Synchronous FIFO, combinational head read; pop on empty is ignored, push on full
// is dropped unless a pop happens in the same cycle.
module ps2_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             pop_ok, push_ok;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign rdata_o = mem_q[rd_ptr_q];

    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard front end: sync pins, deserialise/check 11-bit frames, buffer bytes.
// Pin-to-edge 3 clk; pop at edge T gives data_out/rec_flag from T+1; full FIFO drops and flags overflow.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] data_out,
    output logic       rec_flag,
    output logic       ready,
    output logic       overflow,
    output logic [7:0] frame_err_cnt
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_MAX   = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(FRAME_BITS - 1);

    logic ps2c_s1_q, ps2c_s2_q, ps2c_prev_q;
    logic ps2d_s1_q, ps2d_s2_q;
    logic fe;

    logic [0:0]            state_q, state_d;
    logic [3:0]            bit_idx_q, bit_idx_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [7:0]            err_cnt_q, err_cnt_d;
    logic                  ovf_q, ovf_d;
    logic [7:0]            dout_q, dout_d;
    logic                  rec_q, rec_d;

    logic       push, pop, err_inc;
    logic [7:0] fifo_rdata;
    logic       fifo_full, fifo_empty;

    assign fe = ps2c_prev_q && !ps2c_s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ps2c_s1_q   <= 1'b1;
            ps2c_s2_q   <= 1'b1;
            ps2c_prev_q <= 1'b1;
            ps2d_s1_q   <= 1'b1;
            ps2d_s2_q   <= 1'b1;
        end else begin
            ps2c_s1_q   <= ps2_clk;
            ps2c_s2_q   <= ps2c_s1_q;
            ps2c_prev_q <= ps2c_s2_q;
            ps2d_s1_q   <= ps2_data;
            ps2d_s2_q   <= ps2d_s1_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_idx_d = bit_idx_q;
        frame_d   = frame_q;
        tmo_d     = tmo_q;
        push      = 1'b0;
        err_inc   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmo_d = '0;
                if (fe && !ps2d_s2_q) begin
                    frame_d   = '0;
                    bit_idx_d = 4'd1;
                    state_d   = ST_RECV;
                end
            end
            default: begin
                if (fe) begin
                    tmo_d              = '0;
                    frame_d[bit_idx_q] = ps2d_s2_q;
                    bit_idx_d          = bit_idx_q + 4'd1;
                    if (bit_idx_q == LAST_BIT) begin
                        // Stop bit just landed: judge the whole frame this cycle.
                        state_d   = ST_IDLE;
                        bit_idx_d = '0;
                        push      = frame_ok(frame_d);
                        err_inc   = !frame_ok(frame_d);
                    end
                end else if (tmo_q == TMO_MAX) begin
                    state_d   = ST_IDLE;
                    bit_idx_d = '0;
                    tmo_d     = '0;
                    err_inc   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        pop       = rd_en && !fifo_empty;
        dout_d    = dout_q;
        rec_d     = 1'b0;
        ovf_d     = ovf_q;
        err_cnt_d = err_cnt_q;
        if (pop) begin
            dout_d = fifo_rdata;
            rec_d  = 1'b1;
        end
        if (push && fifo_full && !pop) ovf_d = 1'b1;
        if (err_inc && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            bit_idx_q <= '0;
            frame_q   <= '0;
            tmo_q     <= '0;
            err_cnt_q <= '0;
            ovf_q     <= 1'b0;
            dout_q    <= '0;
            rec_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_idx_q <= bit_idx_d;
            frame_q   <= frame_d;
            tmo_q     <= tmo_d;
            err_cnt_q <= err_cnt_d;
            ovf_q     <= ovf_d;
            dout_q    <= dout_d;
            rec_q     <= rec_d;
        end
    end

    ps2_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (frame_d[8:1]),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign data_out      = dout_q;
    assign rec_flag      = rec_q;
    assign ready         = !fifo_empty;
    assign overflow      = ovf_q;
    assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Bench for ps2_receiver: bit-banged PS/2 frames, scoreboard queue of expected bytes
// checked whenever rec_flag strobes.
module tb_ps2_receiver;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       rd_en = 1'b0;
    logic [7:0] data_out;
    logic       rec_flag;
    logic       ready;
    logic       overflow;
    logic [7:0] frame_err_cnt;

    int         n_checks = 0;
    int         n_errors = 0;
    int         rec_seen = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    ps2_receiver #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (500)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ps2_clk       (ps2_clk),
        .ps2_data      (ps2_data),
        .rd_en         (rd_en),
        .data_out      (data_out),
        .rec_flag      (rec_flag),
        .ready         (ready),
        .overflow      (overflow),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // nbits < 11 sends a truncated frame; the bus is returned to idle afterwards.
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input int nbits = 11);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            tick(25);
            ps2_clk = 1'b0;
            tick(50);
            ps2_clk = 1'b1;
            tick(25);
        end
        ps2_data = 1'b1;
        if (nbits == 11 && !bad_par && !bad_stop) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(b);
            else exp_ovf = 1'b1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        chk("rst_data_out", 32'(data_out), 32'h0);
        chk("rst_rec_flag", 32'(rec_flag), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_overflow", 32'(overflow), 32'h0);
        chk("rst_err_cnt", 32'(frame_err_cnt), 32'h0);
        rst = 1'b0;
        exp_q.delete();
        exp_ovf = 1'b0;
        tick();
    endtask

    task automatic drain(input int n);
        rd_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            chk("drain_rec_flag", 32'(rec_flag), 32'h1);
        end
        rd_en = 1'b0;
        tick();
        chk("drain_rec_flag_end", 32'(rec_flag), 32'h0);
        chk("drain_ready_end", 32'(ready), 32'h0);
        chk("drain_sb_empty", 32'(exp_q.size()), 32'h0);
    endtask

    initial begin : monitor
        forever begin
            @(posedge clk);
            #1;
            if (rec_flag && !rst) begin
                rec_seen++;
                if (exp_q.size() == 0) chk("unexpected_pop", 32'(data_out), 32'hFFFF_FFFF);
                else chk("pop_data", 32'(data_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin : stim
        int base;
        do_reset();

        // single frame, single pop, then pop on empty is ignored
        send_frame(8'h1C, 0, 0);
        chk("t1_ready", 32'(ready), 32'h1);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t1_rec_flag", 32'(rec_flag), 32'h1);
        chk("t1_data_out", 32'(data_out), 32'h1C);
        tick();
        chk("t1_rec_flag_off", 32'(rec_flag), 32'h0);
        chk("t1_ready_off", 32'(ready), 32'h0);
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        chk("t1_empty_pop", 32'(rec_flag), 32'h0);
        chk("t1_hold_data", 32'(data_out), 32'h1C);

        // back-to-back drain
        send_frame(8'h1C, 0, 0);
        send_frame(8'hF0, 0, 0);
        send_frame(8'h1C, 0, 0);
        base = rec_seen;
        drain(3);
        chk("t2_rec_count", 32'(rec_seen - base), 32'd3);
        chk("t2_err_cnt", 32'(frame_err_cnt), 32'h0);

        // bad parity, bad stop
        send_frame(8'h1C, 1, 0);
        chk("t3_ready_par", 32'(ready), 32'h0);
        send_frame(8'h33, 0, 1);
        chk("t3_ready_stop", 32'(ready), 32'h0);
        chk("t3_err_cnt", 32'(frame_err_cnt), 32'h2);

        // overflow
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            send_frame(8'(i), 0, 0);
            if (i == 8) chk("t4_ovf_before", 32'(overflow), 32'h0);
        end
        chk("t4_ovf_after", 32'(overflow), 32'(exp_ovf));
        drain(DEPTH);
        chk("t4_ovf_sticky", 32'(overflow), 32'h1);

        // timeout discards partial frame
        do_reset();
        send_frame(8'h55, 0, 0, 5);
        tick(600);
        chk("t5_err_timeout", 32'(frame_err_cnt), 32'h1);
        chk("t5_ready_none", 32'(ready), 32'h0);
        send_frame(8'h12, 0, 0);
        drain(1);
        chk("t5_err_final", 32'(frame_err_cnt), 32'h1);

        // reset mid-frame
        do_reset();
        send_frame(8'hAA, 0, 0, 6);
        do_reset();
        base = rec_seen;
        send_frame(8'h14, 0, 0);
        drain(1);
        chk("t6_rec_count", 32'(rec_seen - base), 32'd1);
        chk("t6_data_out", 32'(data_out), 32'h14);
        chk("t6_err_cnt", 32'(frame_err_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
